fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_rd_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for the synchronous FIFO (read pointer, occupancy, flags).
// Define FIFO_RD_UNDERFLOW_FLAG_EN to build the sticky rd_err underflow register.
module rca_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module rca #(
    parameter int W = 6
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s
);
    logic [W-1:0] w_c;
    assign w_c[0] = i_ci;
    genvar g;
    for (g = 0; g < W - 1; g++) begin : g_cell
        rca_cell u_cell (
            .i_a (i_a[g]),
            .i_b (i_b[g]),
            .i_ci(w_c[g]),
            .o_s (o_s[g]),
            .o_co(w_c[g+1])
        );
    end
    // Arithmetic is modulo 2^W, so the top stage needs no carry out.
    assign o_s[W-1] = i_a[W-1] ^ i_b[W-1] ^ w_c[W-1];
endmodule

module fifo_rd_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              rd_err
);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AE  = (ADDR_W+1)'(AE_THRESH);

    logic [ADDR_W:0] r_rd_ptr;
    logic            r_rd_valid;
    logic [ADDR_W:0] w_ptr_inc;
    logic [ADDR_W:0] w_count;
    logic            w_empty;
    logic            w_accept;

    rca #(.W(ADDR_W + 1)) u_inc (
        .i_a (r_rd_ptr),
        .i_b (ONE),
        .i_ci(1'b0),
        .o_s (w_ptr_inc)
    );

    // Occupancy = wr_ptr - rd_ptr as two's-complement add.
    rca #(.W(ADDR_W + 1)) u_sub (
        .i_a (wr_ptr),
        .i_b (~r_rd_ptr),
        .i_ci(1'b1),
        .o_s (w_count)
    );

    assign w_empty  = (wr_ptr == r_rd_ptr);
    assign w_accept = rd_en & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_ptr   <= w_accept ? w_ptr_inc : r_rd_ptr;
            r_rd_valid <= w_accept;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
    logic r_rd_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_err <= 1'b0;
        else if (rd_en & w_empty) r_rd_err <= 1'b1;
    end
    assign rd_err = r_rd_err;
`else
    assign rd_err = 1'b0;
`endif

    assign rd_ptr       = r_rd_ptr;
    assign rd_addr      = r_rd_ptr[ADDR_W-1:0];
    assign rd_valid     = r_rd_valid;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_empty = (w_count <= AE);
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed test-plan steps plus random traffic against an arithmetic reference model.
module tb_fifo_rd_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_en = 1'b0;
    logic [5:0] wr_ptr = '0;
    logic [4:0] rd_addr;
    logic [5:0] rd_ptr;
    logic       rd_valid, empty, almost_empty, rd_err;
    logic [5:0] count;

    int n_chk = 0;
    int n_fail = 0;
    int m_rd = 0;
    int m_wr = 0;
    bit m_valid = 0;
    bit m_err = 0;

    fifo_rd_ctrl dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_ptr(wr_ptr),
        .rd_addr(rd_addr), .rd_ptr(rd_ptr), .rd_valid(rd_valid),
        .empty(empty), .almost_empty(almost_empty), .count(count), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int occ();
        return (m_wr - m_rd + 64) % 64;
    endfunction

    task automatic check_all();
        chk("rd_ptr", int'(rd_ptr), m_rd);
        chk("rd_addr", int'(rd_addr), m_rd % 32);
        chk("count", int'(count), occ());
        chk("empty", int'(empty), int'(occ() == 0 && m_wr == m_rd));
        chk("almost_empty", int'(almost_empty), int'(occ() <= 2));
        chk("rd_valid", int'(rd_valid), int'(m_valid));
        chk("rd_err", int'(rd_err), int'(m_err));
    endtask

    // Called at a negedge: drive inputs, check, then advance the model across one rising edge.
    task automatic step(input bit en);
        bit acc;
        rd_en = en;
        wr_ptr = 6'(m_wr);
        #1;
        check_all();
        acc = en && (m_wr != m_rd);
        @(posedge clk);
        if (en && !acc) begin
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
            m_err = 1;
`endif
        end
        m_rd = (m_rd + int'(acc)) % 64;
        m_valid = acc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        m_rd = 0; m_valid = 0; m_err = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // reset state with wr_ptr = 0
        m_wr = 0;
        step(0);

        // three entries, four read requests
        m_wr = 3;
        for (int i = 0; i < 4; i++) step(1);
        step(0);
        chk("empty_after_3", int'(empty), 1);

        // preload rd_ptr to 31, then read across the address wrap
        m_wr = 33;
        for (int i = 0; i < 40 && m_rd != 31; i++) step(1);
        chk("preload31", int'(rd_ptr), 31);
        step(1);
        chk("wrap_ptr32", int'(rd_ptr), 32);
        chk("wrap_addr0", int'(rd_addr), 0);
        step(1);
        step(0);
        chk("end_empty", int'(empty), 1);

        // full-range count and small count
        do_reset();
        m_wr = 32;
        step(0);
        chk("full_count", int'(count), 32);
        chk("full_not_empty", int'(empty), 0);
        m_wr = 2;
        step(0);
        chk("ae_at_2", int'(almost_empty), 1);

        // underflow: drain then read on empty
        step(1); step(1);
        step(1);
        step(0); step(0);
        chk("underflow_ptr", int'(rd_ptr), 2);
        do_reset();
        step(0);

        // reset between edges during a streaming read
        m_wr = 20;
        for (int i = 0; i < 5; i++) step(1);
        rd_en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ptr", int'(rd_ptr), 0);
        chk("async_rst_valid", int'(rd_valid), 0);
        m_rd = 0; m_valid = 0; m_err = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("resume_addr", int'(rd_addr), 1);

        // random traffic with legal write-pointer advances
        for (int i = 0; i < 600; i++) begin
            if (occ() < 32 && $urandom_range(0, 99) < 50) m_wr = (m_wr + 1) % 64;
            step(1'($urandom_range(0, 99) < 55));
        end
        step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
